uart_rx_ctrl: RTL

//  Frame sequencer for the UART receiver. Tracks the start, data, parity and stop phases of a frame.

---
 rtl/uart_rx_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// Frame sequencer for the UART receiver: walks start/data/parity/stop, owns the
// oversample and bit counters, checks framing and pulses data_valid on a clean frame.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [5:0] Prescale,
    input  logic       sampled_bit,
    output logic [4:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err,
    output logic       strt_glitch,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] prescale_q;
    logic       par_acc;
    logic       at_sample;
    logic       at_wrap;
    logic       start_frame;
    logic       valid_nxt;
    logic       glitch_nxt;

    // Prescale is latched at frame start so a mid-frame change cannot shift the sample point.
    assign at_sample = ({1'b0, edge_cnt} == (prescale_q >> 1) + 6'd2);
    assign at_wrap   = ({1'b0, edge_cnt} == prescale_q - 6'd1);

    assign busy        = (state != IDLE);
    assign dat_samp_en = busy;
    assign deser_en    = (state == DATA);

    always_ff @(posedge CLK) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt   = state;
        start_frame = 1'b0;
        valid_nxt   = 1'b0;
        glitch_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_nxt   = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (at_sample && sampled_bit) begin
                    state_nxt  = IDLE;
                    glitch_nxt = 1'b1;
                end else if (at_wrap) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (at_wrap && bit_cnt == LAST_DATA_BIT) begin
                    state_nxt = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_wrap) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (at_wrap) begin
                    state_nxt = IDLE;
                    valid_nxt = !par_err && !stp_err;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            prescale_q  <= '0;
            par_acc     <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            data_valid  <= 1'b0;
            strt_glitch <= 1'b0;
        end else begin
            data_valid  <= valid_nxt;
            strt_glitch <= glitch_nxt;

            if (state_nxt == IDLE || start_frame) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end else if (at_wrap) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + 5'd1;
            end

            // Error flags persist after the frame so software can read them until the next start.
            if (start_frame) begin
                prescale_q <= Prescale;
                par_acc    <= 1'b0;
                par_err    <= 1'b0;
                stp_err    <= 1'b0;
            end else if (at_sample) begin
                case (state)
                    DATA:    par_acc <= par_acc ^ sampled_bit;
                    PARITY:  par_err <= sampled_bit ^ par_acc ^ PAR_TYP;
                    STOP:    stp_err <= ~sampled_bit;
                    default: ;
                endcase
            end
        end
    end

endmodule
